// File: rtl/delay_tap_ctrl.sv
// delay_tap_ctrl: steps a thermometer-coded delay line to a requested tap.
// Before stepping it drops VT compensation, and it waits SETTLE_CYCLES after
// every step. It can also sweep the line from tap 0 to NTAPS, capturing SAMPLE
// at each tap and reporting the first tap where the sampled value flips.
module delay_tap_ctrl #(
    parameter int NTAPS         = 6,
    parameter int SETTLE_CYCLES = 4,
    localparam int TW           = $clog2(NTAPS + 1)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic            REQ_CMD,
    input  logic [TW-1:0]   REQ_TAP,
    input  logic            SAMPLE,
    output logic            DLY_CE,
    output logic            DLY_INC,
    output logic            DLY_EN_VTC,
    output logic [TW-1:0]   CUR_TAP,
    output logic            DONE,
    output logic [NTAPS:0]  SCAN_MAP,
    output logic            EDGE_VALID,
    output logic [TW-1:0]   EDGE_TAP
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_VTC_OFF = 3'd1;
    localparam logic [2:0] ST_STEP    = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_RESTORE = 3'd4;

    localparam int            CW          = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TAP_MAX     = TW'(NTAPS);

    logic [2:0]     state;
    logic [TW-1:0]  cur_tap;
    logic [TW-1:0]  target;
    logic [CW-1:0]  settle_cnt;
    logic           scan_mode;
    logic           scan_up;
    logic           done_q;
    logic [NTAPS:0] scan_map;
    logic           edge_valid;
    logic [TW-1:0]  edge_tap;

    logic [TW-1:0]  req_target;
    logic           step_up;
    logic           at_target;
    logic           edge_found;
    logic [TW-1:0]  edge_idx;

    // Out-of-range targets clamp to the top of the line.
    assign req_target = (REQ_TAP > TAP_MAX) ? TAP_MAX : REQ_TAP;
    assign step_up    = (target > cur_tap);
    assign at_target  = (target == cur_tap);

    // Locate the lowest tap whose captured value differs from the tap below it.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        edge_found = 1'b0;
        edge_idx   = '0;
        // Walk downwards so the lowest transition is the one left standing.
        for (int i = NTAPS; i >= 1; i--) begin
            if (scan_map[i] != scan_map[i-1]) begin
                edge_found = 1'b1;
                edge_idx   = TW'(i);
            end
        end
    end

    // Command FSM, tap tracking, settle timing and scan capture.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (RST) begin
            state      <= ST_IDLE;
            cur_tap    <= '0;
            target     <= '0;
            settle_cnt <= '0;
            scan_mode  <= 1'b0;
            scan_up    <= 1'b0;
            done_q     <= 1'b0;
            // NOTE: scan_map is a visible result register, not a storage array, so it is reset with the rest.
            scan_map   <= '0;
            edge_valid <= 1'b0;
            edge_tap   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        scan_up <= 1'b0;
                        if (REQ_CMD) begin
                            // A scan first walks down to tap 0, then sweeps upwards.
                            scan_mode <= 1'b1;
                            target    <= '0;
                            scan_map  <= '0;
                            state     <= ST_VTC_OFF;
                        end else begin
                            scan_mode <= 1'b0;
                            target    <= req_target;
                            state     <= (req_target == cur_tap) ? ST_RESTORE : ST_VTC_OFF;
                        end
                    end
                end
                ST_VTC_OFF: begin
                    // Only a scan that starts at tap 0 gets here already on target:
                    // it still settles once before capturing tap 0.
                    if (at_target) begin
                        settle_cnt <= SETTLE_LAST;
                        state      <= ST_SETTLE;
                    end else begin
                        state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (step_up) begin
                        if (cur_tap != TAP_MAX) cur_tap <= cur_tap + TW'(1);
                    end else begin
                        if (cur_tap != '0) cur_tap <= cur_tap - TW'(1);
                    end
                    settle_cnt <= SETTLE_LAST;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end else if (scan_mode && (scan_up || at_target)) begin
                        // Sweep phase: capture this tap, then climb or finish.
                        scan_map[cur_tap] <= SAMPLE;
                        scan_up           <= 1'b1;
                        if (cur_tap == TAP_MAX) begin
                            state <= ST_RESTORE;
                        end else begin
                            target <= TAP_MAX;
                            state  <= ST_STEP;
                        end
                    end else if (at_target) begin
                        state <= ST_RESTORE;
                    end else begin
                        state <= ST_STEP;
                    end
                end
                ST_RESTORE: begin
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                    if (scan_mode) begin
                        edge_valid <= edge_found;
                        edge_tap   <= edge_idx;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Line controls decode directly from the state, so VTC is low whenever CE can be high.
    assign REQ_READY  = (state == ST_IDLE);
    assign DLY_CE     = (state == ST_STEP);
    assign DLY_INC    = (state == ST_STEP) && step_up;
    assign DLY_EN_VTC = !((state == ST_VTC_OFF) || (state == ST_STEP) || (state == ST_SETTLE));
    assign CUR_TAP    = cur_tap;
    assign DONE       = done_q;
    assign SCAN_MAP   = scan_map;
    assign EDGE_VALID = edge_valid;
    assign EDGE_TAP   = edge_tap;

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Bench for delay_tap_ctrl. It contains a behavioural delay line driven by
// DLY_CE/DLY_INC, with SAMPLE taken from a per-tap pattern. Expected timing,
// pulse counts and scan results are computed from tap distances and patterns.
module tb_delay_tap_ctrl;

    localparam int NTAPS  = 6;
    localparam int SETTLE = 4;
    localparam int TW     = 3;
    localparam int C      = 1 + SETTLE;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            REQ_VALID = 1'b0;
    logic            REQ_CMD = 1'b0;
    logic [TW-1:0]   REQ_TAP = '0;
    logic            SAMPLE;
    logic            REQ_READY, DLY_CE, DLY_INC, DLY_EN_VTC, DONE, EDGE_VALID;
    logic [TW-1:0]   CUR_TAP, EDGE_TAP;
    logic [NTAPS:0]  SCAN_MAP;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural delay line plus the pattern it presents on SAMPLE.
    logic [NTAPS:0] pattern = '0;
    int line_tap = 0;

    // Model state.
    int model_tap = 0;
    int exp_ev    = 0;
    int exp_et    = 0;

    // Observation results.
    int obs_done_k;
    int n_up, n_dn, vtc_low;
    int ce_k[$];

    always #5 CLK = ~CLK;

    delay_tap_ctrl #(.NTAPS(NTAPS), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CMD(REQ_CMD), .REQ_TAP(REQ_TAP), .SAMPLE(SAMPLE),
        .DLY_CE(DLY_CE), .DLY_INC(DLY_INC), .DLY_EN_VTC(DLY_EN_VTC),
        .CUR_TAP(CUR_TAP), .DONE(DONE), .SCAN_MAP(SCAN_MAP),
        .EDGE_VALID(EDGE_VALID), .EDGE_TAP(EDGE_TAP)
    );

    // The delay line shares RST and ignores CE while VT compensation is on.
    always @(posedge CLK) begin
        if (RST) line_tap <= 0;
        else if (DLY_CE && !DLY_EN_VTC) begin
            if (DLY_INC && line_tap < NTAPS) line_tap <= line_tap + 1;
            else if (!DLY_INC && line_tap > 0) line_tap <= line_tap - 1;
        end
    end

    always_comb SAMPLE = pattern[line_tap];

    // CE must never be issued while VT compensation is enabled.
    always @(negedge CLK) begin
        n_total++;
        if (DLY_CE && DLY_EN_VTC) $display("FAIL ce_while_vtc: ce=%0b en_vtc=%0b required not both 1", DLY_CE, DLY_EN_VTC);
        else n_pass++;
    end

    function automatic int clamp_tap(input int t);
        return (t > NTAPS) ? NTAPS : t;
    endfunction

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Present a command and hold it until accepted; returns just after the accept edge.
    task automatic issue(input logic cmd, input int tap);
        int w;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_CMD = cmd; REQ_TAP = TW'(tap);
        w = 0;
        while (!REQ_READY && w < 1000) begin @(negedge CLK); w++; end
        if (!REQ_READY) begin
            n_total++;
            $display("FAIL issue_timeout: REQ_READY stayed 0 for 1000 cycles");
        end
        @(posedge CLK);
    endtask

    // Watch cycles 1.. after an accept edge until DONE; optionally keep REQ_VALID
    // high with a new command to check that a busy controller ignores it.
    task automatic observe(input bit hold, input logic cmd2, input int tap2);
        obs_done_k = -1; n_up = 0; n_dn = 0; vtc_low = 0; ce_k.delete();
        for (int k = 1; k <= 2000; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                if (hold) begin REQ_CMD = cmd2; REQ_TAP = TW'(tap2); end
                else REQ_VALID = 1'b0;
            end
            if (!DLY_EN_VTC) vtc_low++;
            if (DLY_CE) begin
                ce_k.push_back(k);
                if (DLY_INC) n_up++; else n_dn++;
            end
            if (DONE) begin obs_done_k = k; break; end
        end
        n_total++;
        if (obs_done_k < 0) $display("FAIL done_timeout: no DONE within 2000 cycles");
        else n_pass++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_total++; if (REQ_READY !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", REQ_READY); else n_pass++;
        n_total++; if ({DLY_CE, DLY_INC, DONE} !== 3'b000) $display("FAIL reset_ce_inc_done: got %b expected 000", {DLY_CE, DLY_INC, DONE}); else n_pass++;
        n_total++; if (DLY_EN_VTC !== 1'b1) $display("FAIL reset_en_vtc: got %0b expected 1", DLY_EN_VTC); else n_pass++;
        n_total++; if (CUR_TAP !== 3'd0) $display("FAIL reset_cur_tap: got %0d expected 0", CUR_TAP); else n_pass++;
        n_total++; if ({SCAN_MAP, EDGE_VALID, EDGE_TAP} !== '0) $display("FAIL reset_scan_results: map=%b ev=%0b et=%0d expected all 0", SCAN_MAP, EDGE_VALID, EDGE_TAP); else n_pass++;
        RST = 1'b0;
        model_tap = 0; exp_ev = 0; exp_et = 0;
    endtask

    // Directed SETs (up 3, down to 1, same tap, clamped 7, back to 0) then random targets.
    task automatic test_set_sequence();
        int seq[5] = '{3, 1, 1, 7, 0};
        int req, tgt, d, exp_done, bad_pos;
        for (int n = 0; n < 13; n++) begin
            req = (n < 5) ? seq[n] : int'($urandom_range(0, 7));
            tgt = clamp_tap(req);
            d = abs_diff(tgt, model_tap);
            exp_done = (d == 0) ? 2 : 3 + d * C;
            issue(1'b0, req);
            observe(1'b0, 1'b0, 0);
            n_total++; if (obs_done_k != exp_done) $display("FAIL set_done_cycle: req=%0d got cycle %0d expected %0d", req, obs_done_k, exp_done); else n_pass++;
            n_total++; if (n_up != ((tgt > model_tap) ? d : 0) || n_dn != ((tgt < model_tap) ? d : 0))
                $display("FAIL set_pulses: req=%0d got up=%0d dn=%0d expected %0d steps from %0d", req, n_up, n_dn, d, model_tap);
            else n_pass++;
            bad_pos = 0;
            foreach (ce_k[j]) if (ce_k[j] != 2 + j * C) bad_pos++;
            n_total++; if (bad_pos != 0) $display("FAIL set_pulse_spacing: req=%0d %0d pulses off expected cycles 2+j*%0d", req, bad_pos, C); else n_pass++;
            n_total++; if (vtc_low != ((d == 0) ? 0 : 1 + d * C)) $display("FAIL set_vtc_window: req=%0d got %0d low cycles expected %0d", req, vtc_low, (d == 0) ? 0 : 1 + d * C); else n_pass++;
            model_tap = tgt;
            n_total++; if (CUR_TAP !== TW'(model_tap) || line_tap != model_tap) $display("FAIL set_cur_tap: got cur=%0d line=%0d expected %0d", CUR_TAP, line_tap, model_tap); else n_pass++;
            n_total++; if (DLY_EN_VTC !== 1'b1 || REQ_READY !== 1'b1) $display("FAIL set_done_state: got en_vtc=%0b ready=%0b expected 1 1", DLY_EN_VTC, REQ_READY); else n_pass++;
            n_total++; if (EDGE_VALID !== 1'(exp_ev) || EDGE_TAP !== TW'(exp_et)) $display("FAIL set_edge_kept: got ev=%0b et=%0d expected %0d %0d", EDGE_VALID, EDGE_TAP, exp_ev, exp_et); else n_pass++;
            @(negedge CLK);
            n_total++; if (DONE !== 1'b0) $display("FAIL set_done_width: got DONE=%0b one cycle later, expected 0", DONE); else n_pass++;
        end
    endtask

    // Scans from varied start taps over directed and random SAMPLE patterns.
    task automatic test_scan();
        logic [NTAPS:0] pats[6];
        int s, exp_done;
        pats[0] = 7'b1111000;
        pats[1] = 7'b1111111;
        for (int p = 2; p < 6; p++) pats[p] = (NTAPS + 1)'($urandom);
        for (int p = 0; p < 6; p++) begin
            // Move to a start tap first; tap 0 is exercised once explicitly.
            s = (p == 2) ? 0 : int'($urandom_range(0, NTAPS));
            issue(1'b0, s);
            observe(1'b0, 1'b0, 0);
            model_tap = s;
            pattern = pats[p];
            exp_ev = 0; exp_et = 0;
            for (int i = 1; i <= NTAPS; i++)
                if (exp_ev == 0 && pattern[i] != pattern[i-1]) begin exp_ev = 1; exp_et = i; end
            exp_done = (s == 0) ? 3 + SETTLE + NTAPS * C : 3 + (s + NTAPS) * C;
            issue(1'b1, int'($urandom_range(0, 7)));
            observe(1'b0, 1'b0, 0);
            model_tap = NTAPS;
            n_total++; if (obs_done_k != exp_done) $display("FAIL scan_done_cycle: start=%0d got cycle %0d expected %0d", s, obs_done_k, exp_done); else n_pass++;
            n_total++; if (n_dn != s || n_up != NTAPS) $display("FAIL scan_pulses: start=%0d got up=%0d dn=%0d expected up=%0d dn=%0d", s, n_up, n_dn, NTAPS, s); else n_pass++;
            n_total++; if (vtc_low != exp_done - 2) $display("FAIL scan_vtc_window: got %0d low cycles expected %0d", vtc_low, exp_done - 2); else n_pass++;
            n_total++; if (SCAN_MAP !== pattern) $display("FAIL scan_map: got %b expected %b", SCAN_MAP, pattern); else n_pass++;
            n_total++; if (EDGE_VALID !== 1'(exp_ev) || EDGE_TAP !== TW'(exp_et)) $display("FAIL scan_edge: got ev=%0b et=%0d expected %0d %0d", EDGE_VALID, EDGE_TAP, exp_ev, exp_et); else n_pass++;
            n_total++; if (CUR_TAP !== TW'(NTAPS) || line_tap != NTAPS) $display("FAIL scan_end_tap: got cur=%0d line=%0d expected %0d", CUR_TAP, line_tap, NTAPS); else n_pass++;
        end
    endtask

    // A second request held high during a busy SET is taken only once IDLE returns.
    task automatic test_back_to_back();
        int a, b, da, db;
        for (int n = 0; n < 3; n++) begin
            a = int'($urandom_range(0, NTAPS));
            b = int'($urandom_range(0, 7));
            if (a == model_tap) a = (model_tap + 2) % (NTAPS + 1);
            da = abs_diff(a, model_tap);
            db = abs_diff(clamp_tap(b), a);
            issue(1'b0, a);
            observe(1'b1, 1'b0, b);
            n_total++; if (obs_done_k != 3 + da * C || CUR_TAP !== TW'(a)) $display("FAIL b2b_first: got done=%0d cur=%0d expected %0d %0d", obs_done_k, CUR_TAP, 3 + da * C, a); else n_pass++;
            n_total++; if (n_up + n_dn != da) $display("FAIL b2b_first_pulses: got %0d expected %0d", n_up + n_dn, da); else n_pass++;
            @(posedge CLK);
            observe(1'b0, 1'b0, 0);
            model_tap = clamp_tap(b);
            n_total++; if (obs_done_k != ((db == 0) ? 2 : 3 + db * C) || CUR_TAP !== TW'(model_tap)) $display("FAIL b2b_second: got done=%0d cur=%0d expected %0d %0d", obs_done_k, CUR_TAP, (db == 0) ? 2 : 3 + db * C, model_tap); else n_pass++;
        end
    endtask

    // Reset during the second SETTLE of a SET 5 aborts without DONE; accept resumes at once.
    task automatic test_reset_midop();
        int seen_done;
        issue(1'b0, 0);
        observe(1'b0, 1'b0, 0);
        model_tap = 0;
        issue(1'b0, 5);
        seen_done = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1) REQ_VALID = 1'b0;
            if (DONE) seen_done = 1;
        end
        RST = 1'b1;
        @(negedge CLK);
        if (DONE) seen_done = 1;
        n_total++; if (seen_done != 0) $display("FAIL midrst_no_done: DONE seen during aborted SET, expected none"); else n_pass++;
        n_total++; if ({REQ_READY, DLY_CE, DLY_INC, DLY_EN_VTC} !== 4'b1001) $display("FAIL midrst_ctrl: got ready/ce/inc/vtc=%b expected 1001", {REQ_READY, DLY_CE, DLY_INC, DLY_EN_VTC}); else n_pass++;
        n_total++; if (CUR_TAP !== 3'd0 || line_tap != 0) $display("FAIL midrst_tap: got cur=%0d line=%0d expected 0", CUR_TAP, line_tap); else n_pass++;
        n_total++; if ({SCAN_MAP, EDGE_VALID, EDGE_TAP} !== '0) $display("FAIL midrst_results: map=%b ev=%0b et=%0d expected all 0", SCAN_MAP, EDGE_VALID, EDGE_TAP); else n_pass++;
        model_tap = 0; exp_ev = 0; exp_et = 0;
        RST = 1'b0;
        REQ_VALID = 1'b1; REQ_CMD = 1'b0; REQ_TAP = 3'd2;
        @(posedge CLK);
        observe(1'b0, 1'b0, 0);
        model_tap = 2;
        n_total++; if (obs_done_k != 3 + 2 * C || CUR_TAP !== 3'd2) $display("FAIL midrst_first_accept: got done=%0d cur=%0d expected %0d 2", obs_done_k, CUR_TAP, 3 + 2 * C); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_set_sequence();
        test_scan();
        test_back_to_back();
        test_reset_midop();
        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
